// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_if
// Brief    : Host-write and transmitter-handshake bundle for uart_tx_fifo.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_if #(
   parameter int NBITS      = 8,
   parameter int DEPTH_LOG2 = 4
);
   logic                  i_wr;
   logic [NBITS-1:0]      i_wr_data;
   logic                  i_ovf_clr;
   logic                  i_tx_done;
   logic                  o_tx_start;
   logic [NBITS-1:0]      o_tx_data;
   logic                  o_full;
   logic                  o_empty;
   logic [DEPTH_LOG2:0]   o_count;
   logic                  o_overflow;

   modport master (
      output i_wr, i_wr_data, i_ovf_clr, i_tx_done,
      input  o_tx_start, o_tx_data, o_full, o_empty, o_count, o_overflow
   );

   modport slave (
      input  i_wr, i_wr_data, i_ovf_clr, i_tx_done,
      output o_tx_start, o_tx_data, o_full, o_empty, o_count, o_overflow
   );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : Circular TX FIFO with start/done dispatcher feeding a UART TX.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
   parameter int NBITS      = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  wire logic       clk,
   input  wire logic       rst,
   uart_tx_fifo_if.slave   bus
);
   localparam int                  c_DEPTH    = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] c_CNT_FULL = (DEPTH_LOG2 + 1)'(c_DEPTH);
   localparam logic [DEPTH_LOG2:0] c_CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = DEPTH_LOG2'(1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WAIT_BUSY = 2'd1,
      S_WAIT_DONE = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;
   logic [NBITS-1:0]       r_mem [c_DEPTH];
   logic [DEPTH_LOG2-1:0]  r_wr_ptr;
   logic [DEPTH_LOG2-1:0]  r_rd_ptr;
   logic [DEPTH_LOG2:0]    r_count;
   logic                   r_tx_start;
   logic [NBITS-1:0]       r_tx_data;
   logic                   r_overflow;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_push;
   logic                   w_drop;
   logic                   w_pop;

   assign w_full  = (r_count == c_CNT_FULL);
   assign w_empty = (r_count == '0);
   // Full blocks the write even when a pop frees a slot in the same cycle.
   assign w_push  = bus.i_wr & ~w_full;
   assign w_drop  = bus.i_wr & w_full;

   always_comb begin
      w_state_next = r_state;
      w_pop        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty && bus.i_tx_done) begin
               w_pop        = 1'b1;
               w_state_next = S_WAIT_BUSY;
            end
         end
         S_WAIT_BUSY: begin
            if (!bus.i_tx_done) w_state_next = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (bus.i_tx_done) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= bus.i_wr_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_tx_start <= 1'b0;
         r_tx_data  <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_tx_start <= w_pop;
         if (w_pop) begin
            r_tx_data <= r_mem[r_rd_ptr];
            r_rd_ptr  <= r_rd_ptr + c_PTR_ONE;
         end
         if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (bus.i_ovf_clr) begin
            r_overflow <= 1'b0;
         end
      end
   end

   assign bus.o_tx_start = r_tx_start;
   assign bus.o_tx_data  = r_tx_data;
   assign bus.o_full     = w_full;
   assign bus.o_empty    = w_empty;
   assign bus.o_count    = r_count;
   assign bus.o_overflow = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Queue-model bench for uart_tx_fifo with an emulated transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;
   localparam int NBITS      = 8;
   localparam int DEPTH_LOG2 = 4;
   localparam int DEPTH      = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   uart_tx_fifo_if #(.NBITS(NBITS), .DEPTH_LOG2(DEPTH_LOG2)) bus ();
   uart_tx_fifo #(.NBITS(NBITS), .DEPTH_LOG2(DEPTH_LOG2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] m_q [$];
   logic       m_idle, m_seen_low, m_start, m_ovf;
   logic [7:0] m_data;

   bit         force_en, force_val;
   int         hi_left, lo_left;
   logic [7:0] sent [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Abstract dispatcher: after a start, wait for done to fall then rise.
   task automatic model_edge();
      bit full, empty, pop, push, drop;
      full  = (m_q.size() == DEPTH);
      empty = (m_q.size() == 0);
      pop   = m_idle && !empty && bus.i_tx_done;
      push  = bus.i_wr && !full;
      drop  = bus.i_wr && full;
      m_start = pop;
      if (pop) begin
         m_data     = m_q.pop_front();
         m_idle     = 1'b0;
         m_seen_low = 1'b0;
      end else if (!m_idle) begin
         if (!m_seen_low) begin
            if (!bus.i_tx_done) m_seen_low = 1'b1;
         end else if (bus.i_tx_done) begin
            m_idle = 1'b1;
         end
      end
      if (push) m_q.push_back(bus.i_wr_data);
      if (drop) m_ovf = 1'b1;
      else if (bus.i_ovf_clr) m_ovf = 1'b0;
   endtask

   task automatic compare();
      chk("tx_start", bus.o_tx_start, m_start);
      chk("tx_data", bus.o_tx_data, m_data);
      chk("count", bus.o_count, m_q.size());
      chk("full", bus.o_full, m_q.size() == DEPTH);
      chk("empty", bus.o_empty, m_q.size() == 0);
      chk("overflow", bus.o_overflow, m_ovf);
   endtask

   // Emulated transmitter: done stays high for the start cycle plus two, then a low frame.
   task automatic tick();
      bus.i_tx_done = force_en ? force_val : ((hi_left > 0) || (lo_left == 0));
      if (hi_left > 0) hi_left--;
      else if (lo_left > 0) lo_left--;
      model_edge();
      @(posedge clk);
      #1;
      compare();
      if (bus.o_tx_start) begin
         sent.push_back(bus.o_tx_data);
         hi_left = 3;
         lo_left = $urandom_range(1, 6);
      end
      bus.i_wr      = 1'b0;
      bus.i_ovf_clr = 1'b0;
   endtask

   task automatic do_reset();
      rst           = 1'b0;
      bus.i_wr      = 1'b0;
      bus.i_ovf_clr = 1'b0;
      #1;
      chk("rst_tx_start", bus.o_tx_start, 0);
      chk("rst_tx_data", bus.o_tx_data, 0);
      chk("rst_overflow", bus.o_overflow, 0);
      chk("rst_empty", bus.o_empty, 1);
      chk("rst_full", bus.o_full, 0);
      chk("rst_count", bus.o_count, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      m_q.delete();
      m_idle = 1'b1; m_seen_low = 1'b0; m_start = 1'b0; m_data = '0; m_ovf = 1'b0;
      hi_left = 0; lo_left = 0;
      sent.delete();
   endtask

   task automatic drain();
      int n = 0;
      while ((m_q.size() != 0 || !m_idle || hi_left > 0 || lo_left > 0) && n < 2000) begin
         tick();
         n++;
      end
      if (n >= 2000) chk("drain_timeout", 1, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.i_wr = 1'b0; bus.i_wr_data = '0; bus.i_ovf_clr = 1'b0; bus.i_tx_done = 1'b1;
      force_en = 1'b0; force_val = 1'b0;
      do_reset();

      // Single byte: start in N+2 only.
      bus.i_wr = 1'b1; bus.i_wr_data = 8'hA5;
      tick();
      chk("single_n1_start", bus.o_tx_start, 0);
      chk("single_n1_count", bus.o_count, 1);
      tick();
      chk("single_n2_start", bus.o_tx_start, 1);
      chk("single_n2_data", bus.o_tx_data, 8'hA5);
      drain();
      repeat (10) tick();
      chk("single_starts", sent.size(), 1);

      // Burst of 16.
      sent.delete();
      for (int i = 0; i < 16; i++) begin
         bus.i_wr = 1'b1; bus.i_wr_data = 8'(i + 1);
         tick();
      end
      drain();
      chk("burst_starts", sent.size(), 16);
      for (int i = 0; i < 16; i++) chk("burst_order", sent[i], i + 1);
      chk("burst_empty", bus.o_empty, 1);

      // Full and overflow with the transmitter held busy.
      sent.delete();
      force_en = 1'b1; force_val = 1'b0;
      for (int i = 0; i < 17; i++) begin
         bus.i_wr = 1'b1; bus.i_wr_data = 8'(8'h40 + i);
         tick();
         if (i == 15) begin
            chk("full_count16", bus.o_count, 16);
            chk("full_flag", bus.o_full, 1);
            chk("full_no_ovf_yet", bus.o_overflow, 0);
         end
      end
      chk("ovf_set", bus.o_overflow, 1);
      chk("ovf_count16", bus.o_count, 16);
      bus.i_ovf_clr = 1'b1;
      tick();
      chk("ovf_cleared", bus.o_overflow, 0);

      // Full with a pop in the same cycle as a write.
      force_en = 1'b0;
      bus.i_wr = 1'b1; bus.i_wr_data = 8'h77;
      tick();
      chk("fullpop_count", bus.o_count, 15);
      chk("fullpop_ovf", bus.o_overflow, 1);
      chk("fullpop_start", bus.o_tx_start, 1);
      chk("fullpop_data", bus.o_tx_data, 8'h40);
      drain();
      chk("fullpop_sent", sent.size(), 16);
      for (int i = 0; i < 16; i++) chk("fullpop_order", sent[i], 8'h40 + i);

      // Wrap-around: 40 bytes in bursts of 10.
      bus.i_ovf_clr = 1'b1;
      tick();
      sent.delete();
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < 10; i++) begin
            bus.i_wr = 1'b1; bus.i_wr_data = 8'(b * 10 + i);
            tick();
         end
         drain();
      end
      chk("wrap_sent", sent.size(), 40);
      for (int i = 0; i < 40; i++) chk("wrap_order", sent[i], i);
      chk("wrap_ovf", bus.o_overflow, 0);

      // Randomized traffic against the model.
      for (int c = 0; c < 1500; c++) begin
         bus.i_wr      = ($urandom_range(0, 99) < 45);
         bus.i_wr_data = 8'($urandom);
         bus.i_ovf_clr = ($urandom_range(0, 99) < 3);
         tick();
      end
      drain();

      // Reset mid-transfer with 5 bytes still queued.
      for (int i = 0; i < 6; i++) begin
         bus.i_wr = 1'b1; bus.i_wr_data = 8'(8'hC0 + i);
         tick();
      end
      repeat (3) tick();
      chk("pre_reset_queued", bus.o_count, 5);
      do_reset();
      repeat (12) tick();
      chk("post_reset_no_start", sent.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
